// File: rtl/int_controller_if.sv
// Bus bundle between the interrupt controller and its environment:
// peripheral lines, CPU return strobe, config register port and CPU-side outputs.
interface int_controller_if #(
   parameter int NUM_SRC = 4
);
   logic [NUM_SRC-1:0] src;
   logic               int_ret;
   logic               cfg_w_en;
   logic [1:0]         cfg_addr;
   logic [7:0]         cfg_w_data;
   logic [7:0]         cfg_r_data;
   logic               int_req;
   logic [7:0]         int_en;
   logic [7:0]         int_vec;
   logic               busy;

   // Environment side: peripherals, CPU and I/O decoder
   modport master (
      output src, int_ret, cfg_w_en, cfg_addr, cfg_w_data,
      input  cfg_r_data, int_req, int_en, int_vec, busy
   );

   // Controller side
   modport slave (
      input  src, int_ret, cfg_w_en, cfg_addr, cfg_w_data,
      output cfg_r_data, int_req, int_en, int_vec, busy
   );
endinterface

// File: rtl/int_controller.sv
// Interrupt controller: edge-latched pending bits, mask, single winner dispatch,
// one-cycle request to the CPU, then blocked until the CPU's return.
// Registers: 0 CTRL (bit0 global enable), 1 MASK, 2 PENDING (W1C), 3 VEC_BASE.
// Optional: define INTC_ROUND_ROBIN_EN for rotating priority (search starts
// after the last served index); default is fixed priority, index 0 highest.
module int_controller #(
   parameter int NUM_SRC   = 4,
   parameter int VEC_SHIFT = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   int_controller_if.slave  bus
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             r_state;
   logic [7:0]         r_ctrl;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_pending;
   logic [7:0]         r_vec_base;
   logic [NUM_SRC-1:0] r_src_q;
   logic               r_int_req;
   logic [7:0]         r_int_vec;
   logic               r_busy;

   logic                 w_ctrl_wr;
   logic                 w_mask_wr;
   logic                 w_pend_wr;
   logic                 w_vbase_wr;
   logic [7:0]           w_ctrl_next;
   logic [NUM_SRC-1:0]   w_edge;
   logic [NUM_SRC-1:0]   w_elig;
   logic [2*NUM_SRC-1:0] w_dbl;
   logic [NUM_SRC-1:0]   w_rot;
   int unsigned          w_start;
   int unsigned          w_hit;
   logic                 w_found;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_dispatch;
   logic [NUM_SRC-1:0]   w_onehot;
   logic [NUM_SRC-1:0]   w_clr;
   logic [7:0]           w_off;
   logic [7:0]           w_vec;

`ifdef INTC_ROUND_ROBIN_EN
   logic [IDX_W-1:0]     r_last;
   assign w_start = (32'(r_last) + 32'd1) % NUM_SRC;
`else
   assign w_start = 32'd0;
`endif

   assign w_ctrl_wr   = bus.cfg_w_en && (bus.cfg_addr == 2'd0);
   assign w_mask_wr   = bus.cfg_w_en && (bus.cfg_addr == 2'd1);
   assign w_pend_wr   = bus.cfg_w_en && (bus.cfg_addr == 2'd2);
   assign w_vbase_wr  = bus.cfg_w_en && (bus.cfg_addr == 2'd3);

   // Enable as it will be after this cycle's write, so a disabling write blocks dispatch at once
   assign w_ctrl_next = w_ctrl_wr ? bus.cfg_w_data : r_ctrl;
   assign w_edge      = bus.src & ~r_src_q;
   assign w_elig      = r_pending & r_mask;

   // Rotate eligible bits so the search start sits at bit 0, then take the lowest set bit
   always_comb begin
      w_dbl   = {w_elig, w_elig};
      w_rot   = NUM_SRC'(w_dbl >> w_start);
      w_found = 1'b0;
      w_hit   = 32'd0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_hit   = k;
         end
      end
      w_idx = IDX_W'((w_start + w_hit) % NUM_SRC);
   end

   assign w_dispatch = (r_state == IDLE) && w_ctrl_next[0] && w_found;
   assign w_onehot   = NUM_SRC'(1) << w_idx;
   // A new edge is OR-ed in after clearing, so set beats clear on the same bit
   assign w_clr      = (w_pend_wr  ? bus.cfg_w_data[NUM_SRC-1:0] : '0)
                     | (w_dispatch ? w_onehot                    : '0);
   assign w_off      = 8'(w_idx);
   assign w_vec      = r_vec_base + (w_off << VEC_SHIFT);

   // Configuration registers, source history and pending bits
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_ctrl     <= '0;
         r_mask     <= '0;
         r_pending  <= '0;
         r_vec_base <= '0;
         r_src_q    <= '0;
      end else begin
         r_src_q   <= bus.src;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         r_ctrl    <= w_ctrl_next;
         if (w_mask_wr)  r_mask     <= bus.cfg_w_data[NUM_SRC-1:0];
         if (w_vbase_wr) r_vec_base <= bus.cfg_w_data;
      end
   end

   // Dispatch FSM with registered request, vector and busy outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_int_req <= 1'b0;
         r_int_vec <= '0;
         r_busy    <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
         r_last    <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_dispatch) begin
                  r_state   <= REQ;
                  r_int_req <= 1'b1;
                  r_busy    <= 1'b1;
                  r_int_vec <= w_vec;
`ifdef INTC_ROUND_ROBIN_EN
                  r_last    <= w_idx;
`endif
               end
            end
            REQ: begin
               r_state   <= SERVICE;
               r_int_req <= 1'b0;
            end
            SERVICE: begin
               if (bus.int_ret) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_int_req <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   // Combinational register readback
   always_comb begin
      bus.cfg_r_data = '0;
      case (bus.cfg_addr)
         2'd0:    bus.cfg_r_data = r_ctrl;
         2'd1:    bus.cfg_r_data = 8'(r_mask);
         2'd2:    bus.cfg_r_data = 8'(r_pending);
         default: bus.cfg_r_data = r_vec_base;
      endcase
   end

   assign bus.int_req = r_int_req;
   assign bus.int_en  = r_ctrl;
   assign bus.int_vec = r_int_vec;
   assign bus.busy    = r_busy;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: expected vectors are queued when a
// source is raised and popped by a monitor on each int_req pulse.
module tb_int_controller;

   logic clock;
   logic reset_n;

   int_controller_if #(.NUM_SRC(4)) bus ();

   int_controller #(.NUM_SRC(4), .VEC_SHIFT(2)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int         n_vec  = 0;
   int         n_miss = 0;
   logic [7:0] exp_q[$];
   logic       prev_req = 1'b0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Scoreboard monitor: every request must match the oldest queued vector and last one cycle
   always @(negedge clock) begin
      logic [7:0] e;
      if (bus.int_req === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_req: int_vec=%h, no request was required", bus.int_vec);
         end else begin
            e = exp_q.pop_front();
            if (bus.int_vec !== e) begin
               n_miss++;
               $display("FAIL req_vec: int_vec=%h required %h", bus.int_vec, e);
            end
         end
         n_vec++;
         if (prev_req !== 1'b0) begin
            n_miss++;
            $display("FAIL req_width: int_req high %0d cycles in a row, required 1", 2);
         end
      end
      prev_req = bus.int_req;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.cfg_w_en   = 1'b1;
      bus.cfg_addr   = a;
      bus.cfg_w_data = d;
      tick();
      bus.cfg_w_en   = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      bus.cfg_addr = a;
      #1;
      d = bus.cfg_r_data;
   endtask

   task automatic ret();
      bus.int_ret = 1'b1;
      tick();
      bus.int_ret = 1'b0;
   endtask

   // Counts clock edges until int_req is seen; -1 on timeout
   task automatic wait_req(input int max, output int cyc);
      bit hit;
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < max) begin
         tick();
         cyc++;
         if (bus.int_req === 1'b1) hit = 1'b1;
      end
      if (!hit) begin
         cyc = -1;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset_n        = 1'b0;
      bus.src        = '0;
      bus.int_ret    = 1'b0;
      bus.cfg_w_en   = 1'b0;
      bus.cfg_addr   = 2'd0;
      bus.cfg_w_data = '0;
      repeat (3) tick();
      n_vec++;
      if ({bus.int_req, bus.busy, bus.int_vec, bus.int_en} !== 18'd0) begin
         n_miss++;
         $display("FAIL reset_outputs: req=%b busy=%b vec=%h en=%h required all 0",
                  bus.int_req, bus.busy, bus.int_vec, bus.int_en);
      end
      reset_n = 1'b1;
      tick();
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         n_vec++;
         if (d !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_reg%0d: read %h required 00", a, d);
         end
      end
   endtask

   // Edge to request: src raised in cycle 0, int_req high in cycle 2 (the third cycle)
   task automatic test_single();
      int cyc;
      logic [7:0] d;
      wr(2'd0, 8'h01);
      wr(2'd1, 8'h0F);
      wr(2'd3, 8'h80);
      bus.src = 4'b0100;
      exp_q.push_back(8'h88);
      wait_req(10, cyc);
      bus.src = '0;
      n_vec++;
      if (cyc !== 2) begin
         n_miss++;
         $display("FAIL single_latency: %0d edges to int_req, required 2", cyc);
      end
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_miss++;
         $display("FAIL single_busy: busy=%b required 1", bus.busy);
      end
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h00) begin
         n_miss++;
         $display("FAIL single_pending: read %h required 00", d);
      end
      tick();
      n_vec++;
      if (bus.int_req !== 1'b0 || bus.busy !== 1'b1 || bus.int_vec !== 8'h88) begin
         n_miss++;
         $display("FAIL single_service: req=%b busy=%b vec=%h required 0 1 88",
                  bus.int_req, bus.busy, bus.int_vec);
      end
      ret();
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_miss++;
         $display("FAIL single_ret: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_priority();
      int cyc;
`ifdef INTC_ROUND_ROBIN_EN
      exp_q.push_back(8'h8C);
      exp_q.push_back(8'h84);
`else
      exp_q.push_back(8'h84);
      exp_q.push_back(8'h8C);
`endif
      bus.src = 4'b1010;
      wait_req(10, cyc);
      bus.src = '0;
      n_vec++;
      if (cyc !== 2) begin
         n_miss++;
         $display("FAIL prio_first: %0d edges to int_req, required 2", cyc);
      end
      tick();
      ret();
      wait_req(10, cyc);
      n_vec++;
      if (cyc !== 1) begin
         n_miss++;
         $display("FAIL prio_second: %0d edges after return to int_req, required 1", cyc);
      end
      tick();
      ret();
   endtask

   task automatic test_mask();
      int cyc;
      logic [7:0] d;
      wr(2'd1, 8'h0E);
      bus.src = 4'b0001;
      tick();
      bus.src = '0;
      repeat (3) tick();
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_miss++;
         $display("FAIL mask_blocked: busy=%b required 0", bus.busy);
      end
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h01) begin
         n_miss++;
         $display("FAIL mask_pending: read %h required 01", d);
      end
      exp_q.push_back(8'h80);
      wr(2'd1, 8'h0F);
      wait_req(10, cyc);
      n_vec++;
      if (cyc !== 1) begin
         n_miss++;
         $display("FAIL mask_unmask: %0d edges to int_req, required 1", cyc);
      end
      tick();
      ret();
   endtask

   task automatic test_service_block();
      int cyc;
      logic [7:0] d;
      bus.src = 4'b0001;
      exp_q.push_back(8'h80);
      wait_req(10, cyc);
      bus.src = '0;
      n_vec++;
      if (cyc !== 2) begin
         n_miss++;
         $display("FAIL svc_first: %0d edges to int_req, required 2", cyc);
      end
      // Return during REQ must be ignored
      ret();
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_miss++;
         $display("FAIL svc_early_ret: busy=%b required 1", bus.busy);
      end
      bus.src = 4'b0001;
      exp_q.push_back(8'h80);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (bus.int_req !== 1'b0) begin
            n_miss++;
            $display("FAIL svc_hold: int_req=%b cycle %0d required 0", bus.int_req, i);
         end
      end
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h01) begin
         n_miss++;
         $display("FAIL svc_pending: read %h required 01", d);
      end
      ret();
      wait_req(10, cyc);
      bus.src = '0;
      n_vec++;
      if (cyc !== 1) begin
         n_miss++;
         $display("FAIL svc_after_ret: %0d edges after return to int_req, required 1", cyc);
      end
      tick();
      ret();
   endtask

   task automatic test_ctrl_block();
      logic [7:0] d;
      bus.src = 4'b0001;
      tick();
      bus.src = '0;
      wr(2'd0, 8'h00);
      repeat (3) begin
         tick();
         n_vec++;
         if (bus.int_req !== 1'b0 || bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL ctrl_block: req=%b busy=%b required 0 0", bus.int_req, bus.busy);
         end
      end
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h01) begin
         n_miss++;
         $display("FAIL ctrl_pending: read %h required 01", d);
      end
      bus.src = 4'b0010;
      wr(2'd2, 8'hFF);
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h02) begin
         n_miss++;
         $display("FAIL w1c_set_wins: read %h required 02", d);
      end
      wr(2'd2, 8'hFF);
      bus.src = '0;
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h00) begin
         n_miss++;
         $display("FAIL w1c_clear: read %h required 00", d);
      end
      wr(2'd0, 8'hA5);
      n_vec++;
      if (bus.int_en !== 8'hA5) begin
         n_miss++;
         $display("FAIL int_en: %h required a5", bus.int_en);
      end
   endtask

   task automatic test_wrap_reset();
      int cyc;
      logic [7:0] d;
      wr(2'd3, 8'hFC);
      bus.src = 4'b0010;
      exp_q.push_back(8'h00);
      wait_req(10, cyc);
      bus.src = '0;
      n_vec++;
      if (cyc !== 2) begin
         n_miss++;
         $display("FAIL wrap_latency: %0d edges to int_req, required 2", cyc);
      end
      tick();
      bus.src = 4'b1000;
      tick();
      rd(2'd2, d);
      n_vec++;
      if (d !== 8'h08 || bus.busy !== 1'b1) begin
         n_miss++;
         $display("FAIL wrap_service: pending=%h busy=%b required 08 1", d, bus.busy);
      end
      reset_n = 1'b0;
      tick();
      bus.src = '0;
      n_vec++;
      if ({bus.int_req, bus.busy, bus.int_vec, bus.int_en} !== 18'd0) begin
         n_miss++;
         $display("FAIL midreset_outputs: req=%b busy=%b vec=%h en=%h required all 0",
                  bus.int_req, bus.busy, bus.int_vec, bus.int_en);
      end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         n_vec++;
         if (d !== 8'h00) begin
            n_miss++;
            $display("FAIL midreset_reg%0d: read %h required 00", a, d);
         end
      end
      reset_n = 1'b1;
      repeat (4) tick();
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_miss++;
         $display("FAIL post_reset_idle: busy=%b required 0", bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_service_block();
      test_ctrl_block();
      test_wrap_reset();
      n_vec++;
      if (exp_q.size() !== 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: %0d requests outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
